uart_tx_top: RTL and testbench

- Configurable UART transmitter top level: one clock, runtime-selectable baud rate and parity.
- Serialises an 8-bit byte as start bit, 8 data bits LSB first, optional parity bit and one stop bit on a single line.
- Internally it comprises a baud-tick generator, a parity calculator, a frame shift register and a control FSM.
- Sits between a byte source (enable/din) and the serial output pin.

---
 rtl/uart_tx_top.sv | 115 +++++++++++
 tb/tb_uart_tx_top.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, 8 data bits LSB first, optional odd/even parity, one stop bit.
// Baud rate and parity mode are latched at frame start and held for the whole frame.
module uart_tx_top #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] baud_rate,
    input  logic       enable,
    input  logic [7:0] din,
    input  logic [1:0] parity_type,
    output logic       sending,
    output logic       out
);

    localparam int DIV_2400  = CLK_FREQ / 2400;
    localparam int DIV_4800  = CLK_FREQ / 4800;
    localparam int DIV_9600  = CLK_FREQ / 9600;
    localparam int DIV_19200 = CLK_FREQ / 19200;
    localparam int CW        = $clog2(DIV_2400 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] div_sel, div_q;
    logic [CW-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    data_q;
    logic          par_en_q, par_bit_q;
    logic          load, tick;
    logic          out_next, sending_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        div_sel = CW'(DIV_2400);
        case (baud_rate)
            2'b00:   div_sel = CW'(DIV_2400);
            2'b01:   div_sel = CW'(DIV_4800);
            2'b10:   div_sel = CW'(DIV_9600);
            default: div_sel = CW'(DIV_19200);
        endcase
    end

    assign tick = (baud_cnt == div_q - CW'(1));

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        baud_cnt_next = tick ? '0 : baud_cnt + CW'(1);
        load          = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                if (enable) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) state_next = par_en_q ? PARITY : STOP;
                    else                 bit_cnt_next = bit_cnt + 3'd1;
                end
            end
            PARITY: if (tick) state_next = STOP;
            STOP:   if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Line level is decoded from the next state so out and sending are registered.
        out_next = 1'b1;
        case (state_next)
            START:   out_next = 1'b0;
            DATA:    out_next = data_q[bit_cnt_next];
            PARITY:  out_next = par_bit_q;
            default: out_next = 1'b1;
        endcase
        sending_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            out      <= 1'b1;
            sending  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_cnt  <= bit_cnt_next;
            out      <= out_next;
            sending  <= sending_next;
        end
    end

    // NOTE: frame payload registers need no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q    <= din;
            div_q     <= div_sel;
            par_en_q  <= (parity_type == 2'b01) || (parity_type == 2'b10);
            par_bit_q <= (parity_type == 2'b01) ? ~^din : ^din;
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Self-checking bench for uart_tx_top: directed scenarios plus random frames against a
// frame-level reference model built from the bit-list definition of a UART frame.
module tb_uart_tx_top;

    localparam int CLK_FREQ = 100000;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] baud_rate;
    logic       enable;
    logic [7:0] din;
    logic [1:0] parity_type;
    logic       sending;
    logic       out;

    int vectors     = 0;
    int miscompares = 0;

    logic       keep_en   = 1'b0;
    logic       mid_apply = 1'b0;
    logic [7:0] mid_din;
    logic [1:0] mid_baud;
    logic [1:0] mid_ptype;

    uart_tx_top #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk(clk),
        .reset(reset),
        .baud_rate(baud_rate),
        .enable(enable),
        .din(din),
        .parity_type(parity_type),
        .sending(sending),
        .out(out)
    );

    always #5 clk = ~clk;

    function automatic int div_of(input logic [1:0] b);
        case (b)
            2'b00:   return CLK_FREQ / 2400;
            2'b01:   return CLK_FREQ / 4800;
            2'b10:   return CLK_FREQ / 9600;
            default: return CLK_FREQ / 19200;
        endcase
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called on a falling edge; returns on the falling edge inside the first start-bit cycle.
    task automatic start_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b);
        din         = d;
        parity_type = p;
        baud_rate   = b;
        enable      = 1'b1;
        @(negedge clk);
    endtask

    // Walks the expected bit list, holding each bit for div cycles, then checks the idle cycle.
    task automatic check_frame(input logic [7:0] d, input logic [1:0] p, input int div);
        bit bits[$];
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (p == 2'b01) bits.push_back(($countones(d) % 2) == 0);
        if (p == 2'b10) bits.push_back(($countones(d) % 2) == 1);
        bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++) begin
            for (int k = 0; k < div; k++) begin
                check("frame_out", out, bits[i]);
                check("frame_sending", sending, 1'b1);
                if (i == 0 && k == 0) enable = keep_en;
                if (mid_apply && i == 4 && k == 0) begin
                    din         = mid_din;
                    baud_rate   = mid_baud;
                    parity_type = mid_ptype;
                end
                @(negedge clk);
            end
        end
        check("idle_out", out, 1'b1);
        check("idle_sending", sending, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] p, b;

        reset       = 1'b1;
        enable      = 1'b0;
        din         = 8'h00;
        baud_rate   = 2'b00;
        parity_type = 2'b00;
        repeat (5) @(negedge clk);
        check("reset_out", out, 1'b1);
        check("reset_sending", sending, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("quiet_out", out, 1'b1);
            check("quiet_sending", sending, 1'b0);
        end

        // 2400 baud, odd parity, single-cycle enable pulse
        start_frame(8'hA5, 2'b01, 2'b00);
        check_frame(8'hA5, 2'b01, div_of(2'b00));

        // 9600 baud: even, none, and the alternate none code
        start_frame(8'hA5, 2'b10, 2'b10);
        check_frame(8'hA5, 2'b10, div_of(2'b10));
        start_frame(8'hA5, 2'b00, 2'b10);
        check_frame(8'hA5, 2'b00, div_of(2'b10));
        start_frame(8'hA5, 2'b11, 2'b10);
        check_frame(8'hA5, 2'b11, div_of(2'b10));

        // Continuous mode with din changed mid-frame
        keep_en   = 1'b1;
        mid_apply = 1'b1;
        mid_din   = 8'h81;
        mid_baud  = 2'b11;
        mid_ptype = 2'b01;
        start_frame(8'h3C, 2'b01, 2'b11);
        check_frame(8'h3C, 2'b01, div_of(2'b11));
        keep_en   = 1'b0;
        mid_apply = 1'b0;
        @(negedge clk);
        check_frame(8'h81, 2'b01, div_of(2'b11));
        @(negedge clk);
        check("after_burst_out", out, 1'b1);

        // Reset in the middle of DATA, then a clean frame
        start_frame(8'h5A, 2'b01, 2'b10);
        enable = 1'b0;
        repeat (div_of(2'b10) * 3) @(negedge clk);
        check("mid_data_sending", sending, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_out", out, 1'b1);
        check("abort_sending", sending, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        start_frame(8'hC3, 2'b10, 2'b01);
        check_frame(8'hC3, 2'b10, div_of(2'b01));

        // Baud change mid-frame affects only the next frame
        mid_apply = 1'b1;
        mid_din   = 8'h00;
        mid_baud  = 2'b11;
        mid_ptype = 2'b00;
        start_frame(8'h96, 2'b01, 2'b00);
        check_frame(8'h96, 2'b01, div_of(2'b00));
        mid_apply = 1'b0;
        start_frame(8'h69, 2'b00, 2'b11);
        check_frame(8'h69, 2'b00, div_of(2'b11));

        // Random frames
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            p = 2'($urandom_range(0, 3));
            b = 2'($urandom_range(0, 3));
            start_frame(d, p, b);
            check_frame(d, p, div_of(b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
